branch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 33 +++
 rtl/branch_unit_if.sv | 31 +++
 rtl/branch_cond.sv | 36 +++
 rtl/branch_unit.sv | 104 ++++++++++
 tb/tb_branch_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control-flow path.
//   br_op_t : control-flow opcode encodings presented by decode
//   state_t : branch unit sequencing states
//   PC_W    : program counter width
//   branch_target() : PC-relative target, offset counted in 16-bit words
package cpu_pkg;

  localparam int unsigned PC_W = 16;

  typedef enum logic [2:0] {
    BR_NOP  = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BEZ  = 3'b011,
    BR_BNZ  = 3'b100,
    BR_J    = 3'b101,
    BR_HALT = 3'b110,
    BR_RSVD = 3'b111
  } br_op_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } state_t;

  // Sign-extend the word offset, scale to bytes, add modulo 2^16.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc_next,
                                                    input logic [7:0]      offset);
    return pc_next + {{7{offset[7]}}, offset, 1'b0};
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Decode/fetch <-> branch unit bundle.
//   Requests (decode -> unit): br_valid, br_op, rs, rt, offset, jtarget
//   Status   (unit -> fetch) : pc, flush, taken, halted, taken_count
// master: decode/fetch side, slave: branch unit.
interface branch_unit_if;
  import cpu_pkg::*;

  logic            br_valid;
  br_op_t          br_op;
  logic [PC_W-1:0] rs;
  logic [PC_W-1:0] rt;
  logic [7:0]      offset;
  logic [11:0]     jtarget;

  logic [PC_W-1:0] pc;
  logic            flush;
  logic            taken;
  logic            halted;
  logic [PC_W-1:0] taken_count;

  modport master (
    output br_valid, br_op, rs, rt, offset, jtarget,
    input  pc, flush, taken, halted, taken_count
  );

  modport slave (
    input  br_valid, br_op, rs, rt, offset, jtarget,
    output pc, flush, taken, halted, taken_count
  );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch/jump resolution.
//   br_op, rs, rt, offset, jtarget : decoded request fields
//   pc_next                        : sequential successor of the current PC
//   take                           : request redirects control flow
//   target                         : redirect address (branch or jump form)
// BEZ/BNZ test the whole rt word so any non-zero SLT result counts as true.
module branch_cond
  import cpu_pkg::*;
(
  input  br_op_t          br_op,
  input  logic [PC_W-1:0] rs,
  input  logic [PC_W-1:0] rt,
  input  logic [7:0]      offset,
  input  logic [11:0]     jtarget,
  input  logic [PC_W-1:0] pc_next,
  output logic            take,
  output logic [PC_W-1:0] target
);

  always_comb begin
    take   = 1'b0;
    target = branch_target(pc_next, offset);
    case (br_op)
      BR_BEQ: take = (rs == rt);
      BR_BNE: take = (rs != rt);
      BR_BEZ: take = (rt == '0);
      BR_BNZ: take = (rt != '0);
      BR_J: begin
        take   = 1'b1;
        target = {pc_next[PC_W-1:PC_W-3], jtarget, 1'b0};
      end
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: owns the fetch PC and resolves control flow from decode.
//   clk, reset : clock, asynchronous active-high reset
//   stall_i    : freezes PC and sequencing
//   bus        : request fields in, pc/flush/taken/halted/taken_count out
// A taken branch or jump enters FLUSH for one unstalled cycle so the
// wrong-path instruction in fetch/decode is discarded. HALT is terminal
// until reset.
module branch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     PC_STEP  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall_i,
  branch_unit_if.slave   bus
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(PC_STEP);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            taken_q, taken_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] count_q, count_d;

  logic [PC_W-1:0] pc_next;
  logic            take;
  logic [PC_W-1:0] target;

  assign pc_next = pc_q + PC_INC;

  branch_cond u_cond (
    .br_op   (bus.br_op),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .offset  (bus.offset),
    .jtarget (bus.jtarget),
    .pc_next (pc_next),
    .take    (take),
    .target  (target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        if (!stall_i) begin
          if (bus.br_valid && take) begin
            pc_d    = target;
            state_d = ST_FLUSH;
            taken_d = 1'b1;
            count_d = (count_q == '1) ? count_q : count_q + 1'b1;
          end else if (bus.br_valid && bus.br_op == BR_HALT) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_next;
          end
        end
      end
      ST_FLUSH: begin
        if (!stall_i) begin
          pc_d    = pc_next;
          state_d = ST_RUN;
        end
      end
      ST_HALT: pc_d = pc_q;
      default: state_d = ST_RUN;
    endcase
    // Moore outputs registered from the next state so they line up with state_q.
    flush_d  = (state_d == ST_FLUSH);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      flush_q  <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.flush       = flush_q;
  assign bus.taken       = taken_q;
  assign bus.halted      = halted_q;
  assign bus.taken_count = count_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit. The driver applies one request per cycle
// and queues the hand-computed state expected after that edge; a monitor
// pops and compares on each falling edge.
module tb_branch_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic        flush;
    logic        taken;
    logic        halted;
    logic [15:0] cnt;
  } obs_t;

  logic clk;
  logic reset;
  logic stall_i;

  branch_unit_if bi();

  branch_unit #(.RESET_PC(16'h0100), .PC_STEP(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .stall_i (stall_i),
    .bus     (bi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.pc     = bi.pc;
    o.flush  = bi.flush;
    o.taken  = bi.taken;
    o.halted = bi.halted;
    o.cnt    = bi.taken_count;
    return o;
  endfunction

  task automatic compare(input obs_t e, input string nm);
    obs_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got pc=%h flush=%b taken=%b halted=%b count=%0d, expected pc=%h flush=%b taken=%b halted=%b count=%0d",
               nm, a.pc, a.flush, a.taken, a.halted, a.cnt,
               e.pc, e.flush, e.taken, e.halted, e.cnt);
    end
  endtask

  function automatic obs_t mk(input logic [15:0] pc, input logic fl, input logic tk,
                              input logic hl, input logic [15:0] cnt);
    obs_t o;
    o.pc = pc; o.flush = fl; o.taken = tk; o.halted = hl; o.cnt = cnt;
    return o;
  endfunction

  // Monitor: one queued expectation per falling edge.
  initial begin
    obs_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(e, nm);
      end
    end
  end

  task automatic cyc(input logic v, input br_op_t op, input logic [15:0] a,
                     input logic [15:0] b, input logic [7:0] off, input logic [11:0] jt,
                     input logic st, input logic [15:0] e_pc, input logic e_fl,
                     input logic e_tk, input logic e_hl, input logic [15:0] e_cnt,
                     input string nm);
    bi.br_valid = v;
    bi.br_op    = op;
    bi.rs       = a;
    bi.rt       = b;
    bi.offset   = off;
    bi.jtarget  = jt;
    stall_i     = st;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(e_pc, e_fl, e_tk, e_hl, e_cnt));
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [15:0] e_pc, input logic e_fl, input logic e_tk,
                      input logic [15:0] e_cnt, input string nm);
    cyc(1'b0, BR_NOP, 16'h0, 16'h0, 8'h0, 12'h0, 1'b0, e_pc, e_fl, e_tk, 1'b0, e_cnt, nm);
  endtask

  // Reset asserted between clock edges must take effect before any edge.
  task automatic async_reset_check(input string nm);
    @(negedge clk);
    #1 reset = 1'b1;
    #2 compare(mk(16'h0100, 1'b0, 1'b0, 1'b0, 16'd0), nm);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    stall_i     = 1'b0;
    bi.br_valid = 1'b0;
    bi.br_op    = BR_NOP;
    bi.rs       = '0;
    bi.rt       = '0;
    bi.offset   = '0;
    bi.jtarget  = '0;
    #1;
    exp_q.push_back(mk(16'h0100, 1'b0, 1'b0, 1'b0, 16'd0));
    name_q.push_back("reset_values");
    @(negedge clk);
    #2 reset = 1'b0;

    idle(16'h0102, 0, 0, 16'd0, "seq_0102");
    idle(16'h0104, 0, 0, 16'd0, "seq_0104");
    cyc(1, BR_J, 16'h0, 16'h0, 8'h00, 12'h0FF, 0, 16'h01FE, 1, 1, 0, 16'd1, "j_to_01fe");
    idle(16'h0200, 0, 0, 16'd1, "flush_exit_0200");
    cyc(1, BR_BEZ, 16'h0, 16'h0001, 8'h05, 12'h0, 0, 16'h0202, 0, 0, 0, 16'd1, "bez_slt_true_not_taken");
    cyc(1, BR_BEZ, 16'h0, 16'h0000, 8'h05, 12'h0, 0, 16'h020E, 1, 1, 0, 16'd2, "bez_taken");
    cyc(1, BR_BEQ, 16'h0009, 16'h0009, 8'h10, 12'h0, 0, 16'h0210, 0, 0, 0, 16'd2, "req_ignored_in_flush");
    cyc(1, BR_BNZ, 16'h0, 16'h0100, 8'h02, 12'h0, 0, 16'h0216, 1, 1, 0, 16'd3, "bnz_whole_word");
    idle(16'h0218, 0, 0, 16'd3, "flush_exit_0218");
    cyc(1, BR_BEQ, 16'h0005, 16'h0006, 8'h10, 12'h0, 0, 16'h021A, 0, 0, 0, 16'd3, "beq_not_taken");
    cyc(1, BR_BNE, 16'h0007, 16'h0007, 8'h10, 12'h0, 0, 16'h021C, 0, 0, 0, 16'd3, "bne_not_taken");
    cyc(1, BR_RSVD, 16'h0, 16'h0, 8'h10, 12'h0, 0, 16'h021E, 0, 0, 0, 16'd3, "reserved_is_nop");
    cyc(1, BR_NOP, 16'h0, 16'h0, 8'h10, 12'h0, 0, 16'h0220, 0, 0, 0, 16'd3, "nop");
    cyc(0, BR_BEZ, 16'h0, 16'h0, 8'h10, 12'h0, 0, 16'h0222, 0, 0, 0, 16'd3, "invalid_ignored");
    cyc(1, BR_J, 16'h0, 16'h0, 8'h00, 12'h007, 0, 16'h000E, 1, 1, 0, 16'd4, "j_to_000e");
    idle(16'h0010, 0, 0, 16'd4, "flush_exit_0010");
    cyc(1, BR_BEQ, 16'h0003, 16'h0003, 8'hF8, 12'h0, 0, 16'h0002, 1, 1, 0, 16'd5, "beq_negative_offset");
    idle(16'h0004, 0, 0, 16'd5, "flush_exit_0004");
    cyc(1, BR_BEQ, 16'h0, 16'h0, 8'hF3, 12'h0, 0, 16'hFFEC, 1, 1, 0, 16'd6, "beq_wrap_down");
    idle(16'hFFEE, 0, 0, 16'd6, "flush_exit_ffee");
    cyc(1, BR_J, 16'h0, 16'h0, 8'h00, 12'hABC, 0, 16'hF578, 1, 1, 0, 16'd7, "j_keeps_upper_bits");
    idle(16'hF57A, 0, 0, 16'd7, "flush_exit_f57a");
    cyc(1, BR_J, 16'h0, 16'h0, 8'h00, 12'hFFE, 0, 16'hFFFC, 1, 1, 0, 16'd8, "j_to_fffc");
    idle(16'hFFFE, 0, 0, 16'd8, "flush_exit_fffe");
    cyc(1, BR_BNE, 16'h0001, 16'h0002, 8'h7F, 12'h0, 0, 16'h00FE, 1, 1, 0, 16'd9, "bne_wrap_up");
    for (int i = 0; i < 3; i++)
      cyc(1, BR_J, 16'h0, 16'h0, 8'h00, 12'h123, 1, 16'h00FE, 1, 0, 0, 16'd9, "stall_in_flush");
    idle(16'h0100, 0, 0, 16'd9, "flush_exit_after_stall");
    for (int i = 0; i < 2; i++)
      cyc(1, BR_J, 16'h0, 16'h0, 8'h00, 12'hABC, 1, 16'h0100, 0, 0, 0, 16'd9, "stall_in_run");
    idle(16'h0102, 0, 0, 16'd9, "run_after_stall");
    cyc(1, BR_HALT, 16'h0, 16'h0, 8'h00, 12'h0, 0, 16'h0102, 0, 0, 1, 16'd9, "halt_entry");
    for (int i = 0; i < 10; i++)
      cyc(1, (i % 2 == 0) ? BR_J : BR_BEQ, 16'h0, 16'h0, 8'h04, 12'h055, logic'(i % 3 == 0),
          16'h0102, 0, 0, 1, 16'd9, "halt_frozen");
    async_reset_check("reset_from_halt");
    cyc(1, BR_J, 16'h0, 16'h0, 8'h00, 12'h040, 0, 16'h0080, 1, 1, 0, 16'd1, "j_after_reset");
    async_reset_check("reset_mid_flush");
    idle(16'h0102, 0, 0, 16'd0, "run_after_reset");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
